// File: rtl/updown_count.sv
// updown_count: free-running, wrapping up/down binary counter with a
// terminal-count flag.
//
// Ports
//   clk  - sole clock; the count register updates on the rising edge
//   rst  - synchronous active-high reset; loads val=0 and has priority over counting
//   crt  - direction: 1 = count up, 0 = count down, sampled every edge
//   val  - count value, WIDTH bits, driven straight from the register
//   tc   - terminal count; high when the next non-reset edge wraps val
//
// The arithmetic is modulo 2^WIDTH. The carry or borrow is dropped, so the
// count wraps and never saturates. There is no enable input, so every edge
// without reset moves the count.
module updown_count #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             crt,
   output logic [WIDTH-1:0] val,
   output logic             tc
);

   localparam logic [WIDTH-1:0] VAL_MAX = '1;
   localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);

   logic [WIDTH-1:0] val_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
      end else if (crt) begin
         val_q <= val_q + VAL_ONE;
      end else begin
         val_q <= val_q - VAL_ONE;
      end
   end

   assign val = val_q;

   // tc follows crt directly and is not gated by rst. A parent that asserts
   // reset will still see val return to 0 on that edge.
   always_comb begin
      tc = 1'b0;
      if (crt) begin
         tc = (val_q == VAL_MAX);
      end else begin
         tc = (val_q == '0);
      end
   end

endmodule

// File: tb/tb_updown_count.sv
module tb_updown_count;

   logic       clk;
   logic       rst;
   logic       crt;
   logic [7:0] val8;
   logic       tc8;
   logic [3:0] val4;
   logic       tc4;

   int n_assert;
   int n_fail;
   int m8;
   int m4;

   updown_count #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .crt (crt),
      .val (val8),
      .tc  (tc8)
   );

   updown_count #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .crt (crt),
      .val (val4),
      .tc  (tc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("val8_model", {24'd0, val8}, m8);
      chk("tc8_model", {31'd0, tc8}, ((crt && m8 == 255) || (!crt && m8 == 0)) ? 1 : 0);
      chk("val4_model", {28'd0, val4}, m4);
      chk("tc4_model", {31'd0, tc4}, ((crt && m4 == 15) || (!crt && m4 == 0)) ? 1 : 0);
   endtask

   // One clock edge: advance the reference model from the inputs that were
   // held across the edge, then compare after the register settles.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m8 = 0;
         m4 = 0;
      end else begin
         m8 = (m8 + (crt ? 1 : -1) + 256) % 256;
         m4 = (m4 + (crt ? 1 : -1) + 16) % 16;
      end
      #1;
      check_model();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      m8       = 0;
      m4       = 0;
      rst      = 1'b1;
      crt      = 1'b1;

      // reset held for three edges, then the first counting edge
      repeat (3) tick();
      chk("rst_val", {24'd0, val8}, 0);
      chk("rst_tc", {31'd0, tc8}, 0);
      rst = 1'b0;
      tick();
      chk("first_up", {24'd0, val8}, 1);

      // full up sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      crt = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) begin
         chk("up_val", {24'd0, val8}, i);
         chk("up_tc", {31'd0, tc8}, (i == 255) ? 1 : 0);
         tick();
      end
      chk("up_wrap", {24'd0, val8}, 0);

      // full down sweep from 0
      crt = 1'b0;
      #1;
      chk("down_tc_now", {31'd0, tc8}, 1);
      tick();
      chk("down_wrap", {24'd0, val8}, 255);
      for (int i = 255; i > 0; i--) begin
         chk("down_val", {24'd0, val8}, i);
         chk("down_tc", {31'd0, tc8}, 0);
         tick();
      end
      chk("down_end", {24'd0, val8}, 0);
      chk("down_end_tc", {31'd0, tc8}, 1);

      // direction reversal
      rst = 1'b1;
      tick();
      rst = 1'b0;
      crt = 1'b1;
      repeat (10) tick();
      chk("rev_10", {24'd0, val8}, 10);
      crt = 1'b0;
      tick();
      chk("rev_9", {24'd0, val8}, 9);
      tick();
      chk("rev_8", {24'd0, val8}, 8);
      crt = 1'b1;
      tick();
      chk("rev_back_9", {24'd0, val8}, 9);

      // reset while counting down
      rst = 1'b1;
      crt = 1'b0;
      tick();
      rst = 1'b0;
      repeat (56) tick();
      chk("mid_200", {24'd0, val8}, 200);
      rst = 1'b1;
      tick();
      chk("mid_rst", {24'd0, val8}, 0);
      rst = 1'b0;
      tick();
      chk("mid_resume", {24'd0, val8}, 255);

      // 4-bit instance
      rst = 1'b1;
      tick();
      rst = 1'b0;
      crt = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         chk("w4_val", {28'd0, val4}, i);
         chk("w4_tc", {31'd0, tc4}, (i == 15) ? 1 : 0);
         tick();
      end
      chk("w4_wrap", {28'd0, val4}, 0);
      crt = 1'b0;
      #1;
      chk("w4_down_tc", {31'd0, tc4}, 1);
      tick();
      chk("w4_down_wrap", {28'd0, val4}, 15);

      // random direction with occasional reset
      for (int i = 0; i < 600; i++) begin
         crt = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 24) == 0);
         #1;
         chk("rnd_tc8", {31'd0, tc8}, ((crt && m8 == 255) || (!crt && m8 == 0)) ? 1 : 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_count.md
Name: updown_count

Overview:
- Free-running synchronous up/down binary counter, default width 8 bits.
- The direction input selects increment or decrement on every rising clock edge.
- Generic utility block used wherever a wrapping modulo-2^WIDTH count value is needed.
- Also provides a terminal-count flag so the parent can detect the wrap point.

Parameters:
- WIDTH, default 8, counter width in bits; count range is 0 to 2^WIDTH-1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high. Forces val to 0 on the next rising edge of clk.
- crt  input  1  direction control: 1 = count up, 0 = count down. Sampled at each rising edge.
- val  output  WIDTH  current count value, driven directly from the count register.
- tc  output  1  terminal count, combinational from val and crt: 1 when the next non-reset edge will wrap.

Behaviour:
- Single clock domain. No asynchronous paths except the combinational tc.
- Reset:
  - rst=1 at a rising edge loads val=0, regardless of crt.
  - rst has priority over counting.
  - Reset mid-count returns val to 0 on that edge.
  - Counting resumes on the first edge with rst=0.
  - Before the first clock edge the register value is undefined. A bench must apply rst with at least one clk edge.
- Up count, crt=1, rst=0:
  - val <= val+1 on each rising edge.
  - Wrap: 2^WIDTH-1 -> 0, with no sticking or saturation.
- Down count, crt=0, rst=0:
  - val <= val-1 on each rising edge.
  - Wrap: 0 -> 2^WIDTH-1.
- Latency and timing:
  - val changes exactly one edge after the conditions that cause it. No pipeline delay.
  - val is stable between edges.
- Direction change:
  - Takes effect on the first edge at which the new crt value is sampled.
  - No extra idle cycle and no skipped value. Example: val=5, crt 1->0 before the edge gives 4 after that edge.
- tc:
  - tc = (crt==1 && val==2^WIDTH-1) || (crt==0 && val==0).
  - Changes immediately with crt.
  - Not gated by rst; rst still forces val=0 on the edge.
- Arithmetic is modulo 2^WIDTH. Carry and borrow are discarded.
- No enable input: the counter advances on every non-reset edge.
- Behaviour with crt=X is not required to be defined. The bench holds crt at a known level at every edge.

Test Plan:
- Reset: crt=1, rst=1 for 3 clk edges -> val=0, tc=0. Deassert rst -> first edge gives val=1.
- Full up sweep: after reset, crt=1, 256 edges, check before each edge that val equals the edge index 0..255 -> tc=1 only at val=255, and the 256th edge gives val=0 (wrap).
- Full down sweep: from val=0, set crt=0 -> tc=1 immediately. Edge gives val=255, then decrements by 1 per edge. After 256 edges val=0 again, with tc=1 only at val=0.
- Direction reversal mid-count: count up to val=10, set crt=0 -> next edge val=9, following edge 8. Set crt=1 -> next edge val=9.
- Reset mid-operation: at val=200 counting down, assert rst for one edge -> val=0 on that edge. Release with crt=0 -> next edge val=255.
- Parameter check: WIDTH=4, crt=1 -> sequence 0..15 then 0, tc=1 at val=15. With crt=0, 0 -> 15.
